// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect sequencer. Arbitrates writeback/execute/decode redirect
// requests, waits out any in-flight icache transaction, then emits a single
// registered need_jump/jump_pc pulse into IF0 with per-stage flush levels.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_valid,
  input  logic [31:0]      exc_pc,
  input  logic             br_valid,
  input  logic [31:0]      br_pc,
  input  logic             pd_valid,
  input  logic [31:0]      pd_pc,
  input  logic             ic_busy,
  output logic             need_jump,
  output logic [31:0]      jump_pc,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic [1:0]       epoch,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  // Source priority: larger value means older instruction, wins arbitration.
  localparam logic [1:0] PRIO_PD  = 2'd0;
  localparam logic [1:0] PRIO_BR  = 2'd1;
  localparam logic [1:0] PRIO_EXC = 2'd2;

  // Flush level encoding {EX, ID, IF}.
  localparam logic [2:0] LVL_PD  = 3'b001;
  localparam logic [2:0] LVL_BR  = 3'b011;
  localparam logic [2:0] LVL_EXC = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Statistics counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [1:0]       prio_q, prio_d;
  logic [2:0]       lvl_q, lvl_d;

  logic             need_jump_q, need_jump_d;
  logic [31:0]      jump_pc_q, jump_pc_d;
  logic [2:0]       flush_q, flush_d;
  logic [1:0]       epoch_q, epoch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_any;
  logic [1:0]       req_prio;
  logic [31:0]      req_pc;
  logic [2:0]       req_lvl;
  logic             take;

  // Same-cycle arbitration: exc > br > pd, losers are dropped.
  always_comb begin
    req_any  = exc_valid | br_valid | pd_valid;
    req_prio = PRIO_PD;
    req_pc   = pd_pc;
    req_lvl  = LVL_PD;
    if (br_valid) begin
      req_prio = PRIO_BR;
      req_pc   = br_pc;
      req_lvl  = LVL_BR;
    end
    if (exc_valid) begin
      req_prio = PRIO_EXC;
      req_pc   = exc_pc;
      req_lvl  = LVL_EXC;
    end
  end

  // Next-state, latched redirect and registered output values.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    prio_d  = prio_q;
    lvl_d   = lvl_q;
    take    = 1'b0;

    case (state_q)
      S_IDLE, S_ISSUE: begin
        take    = req_any;
        state_d = req_any ? (ic_busy ? S_DRAIN : S_ISSUE) : S_IDLE;
      end
      S_DRAIN: begin
        // A lower-priority request is younger than the pending redirect and
        // will be flushed by it, so only equal-or-older requests replace it.
        take    = req_any && (req_prio >= prio_q);
        state_d = ic_busy ? S_DRAIN : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      tgt_d  = req_pc;
      prio_d = req_prio;
      lvl_d  = req_lvl;
    end

    need_jump_d = (state_d == S_ISSUE);
    jump_pc_d   = need_jump_d ? tgt_d : jump_pc_q;
    flush_d     = (state_d != S_IDLE) ? lvl_d : 3'b000;
    epoch_d     = need_jump_d ? epoch_q + 2'd1 : epoch_q;
    cnt_d       = need_jump_d ? sat_inc(cnt_q) : cnt_q;
  end

  // Control state and visible outputs; async reset discards any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      need_jump_q <= 1'b0;
      jump_pc_q   <= RESET_PC;
      flush_q     <= 3'b000;
      epoch_q     <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      need_jump_q <= need_jump_d;
      jump_pc_q   <= jump_pc_d;
      flush_q     <= flush_d;
      epoch_q     <= epoch_d;
      cnt_q       <= cnt_d;
    end
  end

  // Latched redirect payload; only meaningful while DRAIN/ISSUE.
  always_ff @(posedge clk) begin
    tgt_q  <= tgt_d;
    prio_q <= prio_d;
    lvl_q  <= lvl_d;
  end

  assign need_jump    = need_jump_q;
  assign jump_pc      = jump_pc_q;
  assign flush_IF     = flush_q[0];
  assign flush_ID     = flush_q[1];
  assign flush_EX     = flush_q[2];
  assign epoch        = epoch_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl. A second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid, br_valid, pd_valid, ic_busy;
  logic [31:0] exc_pc, br_pc, pd_pc;

  logic        need_jump, flush_IF, flush_ID, flush_EX;
  logic [31:0] jump_pc;
  logic [1:0]  epoch;
  logic [31:0] redirect_cnt;

  logic        need_jump2, flush_IF2, flush_ID2, flush_EX2;
  logic [31:0] jump_pc2;
  logic [1:0]  epoch2;
  logic [1:0]  redirect_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .pd_valid(pd_valid), .pd_pc(pd_pc),
    .ic_busy(ic_busy),
    .need_jump(need_jump), .jump_pc(jump_pc),
    .flush_IF(flush_IF), .flush_ID(flush_ID), .flush_EX(flush_EX),
    .epoch(epoch), .redirect_cnt(redirect_cnt)
  );

  fetch_redirect_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .pd_valid(pd_valid), .pd_pc(pd_pc),
    .ic_busy(ic_busy),
    .need_jump(need_jump2), .jump_pc(jump_pc2),
    .flush_IF(flush_IF2), .flush_ID(flush_ID2), .flush_EX(flush_EX2),
    .epoch(epoch2), .redirect_cnt(redirect_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic nj, input logic [31:0] pc,
                         input logic [2:0] fl);
    chk({tag, ".need_jump"}, {31'd0, need_jump}, {31'd0, nj});
    chk({tag, ".jump_pc"}, jump_pc, pc);
    chk({tag, ".flush"}, {29'd0, flush_EX, flush_ID, flush_IF}, {29'd0, fl});
  endtask

  int nf, nj_cnt, nj_at, id_cnt;

  initial begin
    rst_n = 1'b0;
    exc_valid = 1'b0; br_valid = 1'b0; pd_valid = 1'b0; ic_busy = 1'b0;
    exc_pc = '0; br_pc = '0; pd_pc = '0;

    // Reset state
    tick(); tick();
    chk_out("reset", 1'b0, 32'h1c000000, 3'b000);
    chk("reset.epoch", {30'd0, epoch}, 32'd0);
    chk("reset.cnt", redirect_cnt, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b0, 32'h1c000000, 3'b000);

    // Single branch redirect, icache idle
    br_valid = 1'b1; br_pc = 32'h1c000100;
    tick();
    br_valid = 1'b0;
    chk_out("br", 1'b1, 32'h1c000100, 3'b011);
    chk("br.epoch", {30'd0, epoch}, 32'd1);
    chk("br.cnt", redirect_cnt, 32'd1);
    tick();
    chk_out("br_after", 1'b0, 32'h1c000100, 3'b000);

    // All three sources at once: exc wins
    exc_valid = 1'b1; exc_pc = 32'h1c008000;
    br_valid = 1'b1;  br_pc = 32'h1c000200;
    pd_valid = 1'b1;  pd_pc = 32'h1c000020;
    tick();
    exc_valid = 1'b0; br_valid = 1'b0; pd_valid = 1'b0;
    chk_out("arb", 1'b1, 32'h1c008000, 3'b111);
    chk("arb.cnt", redirect_cnt, 32'd2);
    chk("arb.cnt_sat_inst", {30'd0, redirect_cnt2}, 32'd2);
    tick();
    chk_out("arb_after", 1'b0, 32'h1c008000, 3'b000);

    // Predecode redirect while icache busy for 4 sampled edges
    pd_valid = 1'b1; pd_pc = 32'h1c000040; ic_busy = 1'b1;
    tick();
    pd_valid = 1'b0;
    nf = 0; nj_cnt = 0; nj_at = -1; id_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (flush_IF) nf++;
      if (flush_ID || flush_EX) id_cnt++;
      if (need_jump) begin
        nj_cnt++;
        nj_at = i;
        chk("drain.jump_pc", jump_pc, 32'h1c000040);
      end
      ic_busy = (i < 3);
      tick();
    end
    chk("drain.flushIF_cycles", nf, 32'd5);
    chk("drain.nj_count", nj_cnt, 32'd1);
    chk("drain.nj_cycle", nj_at, 32'd4);
    chk("drain.flushIDEX_cycles", id_cnt, 32'd0);
    chk("drain.epoch", {30'd0, epoch}, 32'd3);

    // Replacement in DRAIN by br, then younger pd ignored
    pd_valid = 1'b1; pd_pc = 32'h1c000050; ic_busy = 1'b1;
    tick();
    pd_valid = 1'b0;
    chk_out("repl.pd", 1'b0, 32'h1c000040, 3'b001);
    br_valid = 1'b1; br_pc = 32'h1c000300;
    tick();
    br_valid = 1'b0;
    chk_out("repl.br", 1'b0, 32'h1c000040, 3'b011);
    pd_valid = 1'b1; pd_pc = 32'h1c000060;
    tick();
    pd_valid = 1'b0;
    chk_out("repl.pd_ignored", 1'b0, 32'h1c000040, 3'b011);
    ic_busy = 1'b0;
    tick();
    chk_out("repl.issue", 1'b1, 32'h1c000300, 3'b011);
    chk("repl.epoch", {30'd0, epoch}, 32'd0);
    chk("repl.cnt", redirect_cnt, 32'd4);
    tick();
    chk_out("repl.after", 1'b0, 32'h1c000300, 3'b000);

    // Four back-to-back redirects: epoch 1,2,3,0
    for (int k = 0; k < 4; k++) begin
      br_valid = 1'b1; br_pc = 32'h1c001000 + 32'(k * 4);
      tick();
      chk_out("b2b", 1'b1, 32'h1c001000 + 32'(k * 4), 3'b011);
      chk("b2b.epoch", {30'd0, epoch}, 32'((k + 1) % 4));
    end
    br_valid = 1'b0;
    tick();
    chk_out("b2b.after", 1'b0, 32'h1c00100c, 3'b000);
    chk("b2b.cnt", redirect_cnt, 32'd8);
    chk("b2b.cnt_saturated", {30'd0, redirect_cnt2}, 32'd3);

    // Asynchronous reset in the middle of DRAIN
    pd_valid = 1'b1; pd_pc = 32'h1c000070; ic_busy = 1'b1;
    tick();
    pd_valid = 1'b0;
    chk_out("rst.drain", 1'b0, 32'h1c00100c, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 32'h1c000000, 3'b000);
    chk("rst.epoch", {30'd0, epoch}, 32'd0);
    chk("rst.cnt", redirect_cnt, 32'd0);
    ic_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_out("rst.no_pulse", 1'b0, 32'h1c000000, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Redirect sequencer for the front end: collects PC redirect requests from the writeback stage (exception/ertn), execute stage (branch mispredict) and decode stage (predecode correction of the BPU). It picks the oldest by priority and waits out any in-flight icache transaction. It then drives a single-cycle `need_jump`/`jump_pc` pulse into IF0, together with per-stage flush levels. It sits between the backend redirect sources and IF0/icache, and replaces ad-hoc wiring of `need_jump`/`flush_IF`.

## Interface
- RESET_PC, 32'h1c000000, value driven on `jump_pc` while idle after reset
- CNT_W, 32, width of the redirect statistics counter
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- exc_valid  in  1  WB redirect request (exception/ertn), priority 2 (highest)
- exc_pc  in  32  WB redirect target
- br_valid  in  1  EX mispredict redirect, priority 1
- br_pc  in  32  EX redirect target
- pd_valid  in  1  ID predecode correction, priority 0
- pd_pc  in  32  ID redirect target
- ic_busy  in  1  icache has an accepted request not yet returned
- need_jump  out  1  one-cycle redirect pulse to IF0
- jump_pc  out  32  redirect target, valid with `need_jump`
- flush_IF  out  1  flush IF0/IF1 bus registers
- flush_ID  out  1  flush ID stage
- flush_EX  out  1  flush EX stage
- epoch  out  2  fetch epoch, increments on every `need_jump`
- redirect_cnt  out  CNT_W  count of issued redirects, saturating

## Operation
- Arbitration, same cycle: exc > br > pd. Lower-priority requests in that cycle are dropped.
- Flush level by source:
  - exc: IF+ID+EX.
  - br: IF+ID.
  - pd: IF only.
- States:
  - IDLE: nothing pending.
  - DRAIN: redirect latched, waiting for `ic_busy`=0.
  - ISSUE: pulse cycle.
- IDLE, request arrives:
  - Latch target, priority and level.
  - If `ic_busy`=0, go to ISSUE; otherwise go to DRAIN.
- DRAIN:
  - Flush outputs held at the latched level every cycle.
  - A new request of equal or higher priority replaces target, priority and level. A lower-priority request is ignored, because it is younger and already flushed.
  - Go to ISSUE in the cycle after `ic_busy` is sampled 0.
- ISSUE:
  - `need_jump`=1, `jump_pc`=latched target, flush outputs at the latched level.
  - `epoch` += 1 (wraps 3→0). `redirect_cnt` += 1, saturating at all-ones.
  - Next state:
    - New request this cycle: latch it and go to ISSUE again if `ic_busy`=0, or DRAIN otherwise.
    - No request: go to IDLE.
- IDLE outputs:
  - `need_jump`=0, all flushes 0.
  - `jump_pc` holds the last issued target (RESET_PC after reset).
- Replacement in DRAIN resets nothing else; `epoch` changes only in ISSUE.

## Timing
- All outputs are registered.
- Reset (asynchronous, on `rst_n` low): state IDLE, `need_jump`=0, flush_IF/ID/EX=0, `jump_pc`=RESET_PC, `epoch`=0, `redirect_cnt`=0.
- Reset asserted mid-DRAIN or mid-ISSUE discards the pending redirect immediately. No pulse follows deassertion.
- Latency with `ic_busy`=0: request sampled at edge N → `need_jump` and flushes high in cycle N+1 for exactly one cycle.
- Latency with `ic_busy`=1 at N: flushes high from N+1. `need_jump` is high in cycle M+1, where M is the first edge with `ic_busy`=0. Flushes stay high through M+1 and drop in M+2 unless a new redirect is issued.
- `need_jump` is never high in two consecutive cycles with the same target unless two requests were accepted.
- Simultaneous events:
  - exc and br in the same cycle → exc wins, level IF+ID+EX.
  - Request in the ISSUE cycle → handled as new; the current pulse is unaffected.

## Test plan
- Single br_valid, br_pc=0x1c000100, ic_busy=0 → cycle+1: need_jump=1, jump_pc=0x1c000100, flush_IF=flush_ID=1, flush_EX=0; epoch 0→1; cycle+2 all low.
- exc_valid(0x1c008000), br_valid(0x1c000200) and pd_valid in the same cycle → single pulse to 0x1c008000, all three flushes, redirect_cnt=1.
- pd_valid(0x1c000040) with ic_busy=1 for 4 cycles → flush_IF high 5 cycles, need_jump only in the cycle after ic_busy falls; flush_ID/EX stay 0.
- In DRAIN for pd: br_valid(0x1c000300) arrives → replaces, pulse carries 0x1c000300 with ID flush. Then a pd_valid during the br DRAIN → ignored.
- Four back-to-back accepted redirects → epoch sequence 1,2,3,0; redirect_cnt=4. With CNT_W=2, four redirects saturate at 3.
- rst_n low during DRAIN → outputs return to reset values asynchronously. No need_jump after rst_n rises; jump_pc=0x1c000000.
